// File: rtl/four_bit_max_tracker.sv
// Running-maximum tracker wrapped around an external four-bit magnitude comparator.
// Keeps per-outcome event counters, a sample counter, a result strobe and a sticky flag-error bit.
module four_bit_max_tracker #(
    parameter int CNT_W = 8,
    parameter bit SAT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       in_data,
    output logic [3:0]       cmp_a,
    output logic [3:0]       cmp_b,
    input  logic             cmp_eq,
    input  logic             cmp_gr,
    input  logic             cmp_lt,
    output logic [3:0]       max_out,
    output logic             max_valid,
    output logic [CNT_W-1:0] cnt_gr,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] sample_cnt,
    output logic             out_valid,
    output logic             flag_err
);

    localparam logic [0:0]       ST_EMPTY = 1'b0;
    localparam logic [0:0]       ST_TRACK = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [0:0]       r_state;
    logic [3:0]       r_max;
    logic [CNT_W-1:0] r_cnt_gr;
    logic [CNT_W-1:0] r_cnt_eq;
    logic [CNT_W-1:0] r_cnt_lt;
    logic [CNT_W-1:0] r_sample_cnt;
    logic             r_out_valid;
    logic             r_flag_err;

    logic [1:0]       w_flag_sum;
    logic             w_flags_onehot;

    // Counter step: hold at all-ones when saturating, otherwise wrap naturally.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
        if (SAT && (v == CNT_MAX))
            return v;
        return v + CNT_W'(1);
    endfunction

    assign w_flag_sum     = {1'b0, cmp_eq} + {1'b0, cmp_gr} + {1'b0, cmp_lt};
    assign w_flags_onehot = (w_flag_sum == 2'd1);

    // NOTE: reset and clear share one branch, so a sample presented with clear is dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state      <= ST_EMPTY;
            r_max        <= '0;
            r_cnt_gr     <= '0;
            r_cnt_eq     <= '0;
            r_cnt_lt     <= '0;
            r_sample_cnt <= '0;
            r_out_valid  <= 1'b0;
            r_flag_err   <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                case (r_state)
                    ST_EMPTY: begin
                        r_max        <= in_data;
                        r_sample_cnt <= CNT_W'(1);
                        r_state      <= ST_TRACK;
                    end
                    ST_TRACK: begin
                        r_sample_cnt <= bump(r_sample_cnt);
                        if (!w_flags_onehot) begin
                            r_flag_err <= 1'b1;
                        end else if (cmp_gr) begin
                            r_max    <= in_data;
                            r_cnt_gr <= bump(r_cnt_gr);
                        end else if (cmp_eq) begin
                            r_cnt_eq <= bump(r_cnt_eq);
                        end else begin
                            r_cnt_lt <= bump(r_cnt_lt);
                        end
                    end
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign cmp_a      = in_data;
    assign cmp_b      = r_max;
    assign max_out    = r_max;
    assign max_valid  = (r_state == ST_TRACK);
    assign cnt_gr     = r_cnt_gr;
    assign cnt_eq     = r_cnt_eq;
    assign cnt_lt     = r_cnt_lt;
    assign sample_cnt = r_sample_cnt;
    assign out_valid  = r_out_valid;
    assign flag_err   = r_flag_err;

endmodule

// File: tb/tb_four_bit_max_tracker.sv
// Bench for four_bit_max_tracker: three instances (8-bit saturating, 2-bit saturating, 2-bit wrapping)
// share one stimulus stream; instance 0 can have its comparator flags overridden with bad patterns.
module tb_four_bit_max_tracker;

    logic       clk = 1'b0;
    logic       rst_n, clear, in_valid;
    logic [3:0] in_data;
    logic       fault_en;
    logic [2:0] fault_flags; // {eq, gr, lt}

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instance 0: CNT_W=8, SAT=1, comparator flags may be forced.
    logic [3:0] a0, b0, max0;
    logic       eq0, gr0, lt0, mv0, ov0, fe0;
    logic [7:0] cg0, ce0, cl0, sc0;
    assign eq0 = fault_en ? fault_flags[2] : (a0 == b0);
    assign gr0 = fault_en ? fault_flags[1] : (a0 > b0);
    assign lt0 = fault_en ? fault_flags[0] : (a0 < b0);

    four_bit_max_tracker #(.CNT_W(8), .SAT(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .cmp_a(a0), .cmp_b(b0), .cmp_eq(eq0), .cmp_gr(gr0), .cmp_lt(lt0),
        .max_out(max0), .max_valid(mv0), .cnt_gr(cg0), .cnt_eq(ce0), .cnt_lt(cl0),
        .sample_cnt(sc0), .out_valid(ov0), .flag_err(fe0)
    );

    // Instance 1: CNT_W=2, SAT=1.
    logic [3:0] a1, b1, max1;
    logic       eq1, gr1, lt1, mv1, ov1, fe1;
    logic [1:0] cg1, ce1, cl1, sc1;
    assign eq1 = (a1 == b1);
    assign gr1 = (a1 > b1);
    assign lt1 = (a1 < b1);

    four_bit_max_tracker #(.CNT_W(2), .SAT(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .cmp_a(a1), .cmp_b(b1), .cmp_eq(eq1), .cmp_gr(gr1), .cmp_lt(lt1),
        .max_out(max1), .max_valid(mv1), .cnt_gr(cg1), .cnt_eq(ce1), .cnt_lt(cl1),
        .sample_cnt(sc1), .out_valid(ov1), .flag_err(fe1)
    );

    // Instance 2: CNT_W=2, SAT=0.
    logic [3:0] a2, b2, max2;
    logic       eq2, gr2, lt2, mv2, ov2, fe2;
    logic [1:0] cg2, ce2, cl2, sc2;
    assign eq2 = (a2 == b2);
    assign gr2 = (a2 > b2);
    assign lt2 = (a2 < b2);

    four_bit_max_tracker #(.CNT_W(2), .SAT(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .cmp_a(a2), .cmp_b(b2), .cmp_eq(eq2), .cmp_gr(gr2), .cmp_lt(lt2),
        .max_out(max2), .max_valid(mv2), .cnt_gr(cg2), .cnt_eq(ce2), .cnt_lt(cl2),
        .sample_cnt(sc2), .out_valid(ov2), .flag_err(fe2)
    );

    // Reference model: unbounded event tallies, mapped onto each instance's counter width at compare time.
    int m_max   [3];
    bit m_valid [3];
    int m_gr    [3];
    int m_eq    [3];
    int m_lt    [3];
    int m_samp  [3];
    bit m_ov    [3];
    bit m_err   [3];
    int w_of    [3] = '{8, 2, 2};
    bit sat_of  [3] = '{1'b1, 1'b1, 1'b0};

    logic [2:0] bad_pat [5] = '{3'b000, 3'b110, 3'b101, 3'b011, 3'b111};

    function automatic int view(input int k, input int n);
        int top;
        top = (1 << w_of[k]) - 1;
        if (sat_of[k])
            return (n > top) ? top : n;
        return n % (top + 1);
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            if (!rst_n || clear) begin
                m_max[k] = 0; m_valid[k] = 1'b0; m_gr[k] = 0; m_eq[k] = 0;
                m_lt[k] = 0; m_samp[k] = 0; m_ov[k] = 1'b0; m_err[k] = 1'b0;
            end else if (in_valid) begin
                m_ov[k] = 1'b1;
                if (!m_valid[k]) begin
                    m_valid[k] = 1'b1;
                    m_max[k]   = int'(in_data);
                    m_samp[k]  = 1;
                end else begin
                    m_samp[k]++;
                    if (k == 0 && fault_en)          m_err[k] = 1'b1;
                    else if (int'(in_data) > m_max[k]) begin
                        m_max[k] = int'(in_data);
                        m_gr[k]++;
                    end
                    else if (int'(in_data) == m_max[k]) m_eq[k]++;
                    else                                m_lt[k]++;
                end
            end else begin
                m_ov[k] = 1'b0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_inst(input int k, input logic [3:0] ca, input logic [3:0] cb,
                              input logic [3:0] mx, input logic mv, input logic [31:0] g,
                              input logic [31:0] e, input logic [31:0] l, input logic [31:0] s,
                              input logic ov, input logic fe);
        check($sformatf("i%0d_cmp_a", k), 32'(ca), 32'(in_data));
        check($sformatf("i%0d_cmp_b", k), 32'(cb), m_max[k]);
        check($sformatf("i%0d_max_out", k), 32'(mx), m_max[k]);
        check($sformatf("i%0d_max_valid", k), 32'(mv), 32'(m_valid[k]));
        check($sformatf("i%0d_cnt_gr", k), g, view(k, m_gr[k]));
        check($sformatf("i%0d_cnt_eq", k), e, view(k, m_eq[k]));
        check($sformatf("i%0d_cnt_lt", k), l, view(k, m_lt[k]));
        check($sformatf("i%0d_sample_cnt", k), s, view(k, m_samp[k]));
        check($sformatf("i%0d_out_valid", k), 32'(ov), 32'(m_ov[k]));
        check($sformatf("i%0d_flag_err", k), 32'(fe), 32'(m_err[k]));
    endtask

    task automatic step(input bit r, input bit c, input bit v, input logic [3:0] d,
                        input bit f, input logic [2:0] ff);
        rst_n = r; clear = c; in_valid = v; in_data = d; fault_en = f; fault_flags = ff;
        @(posedge clk);
        model_edge();
        #1;
        check_inst(0, a0, b0, max0, mv0, 32'(cg0), 32'(ce0), 32'(cl0), 32'(sc0), ov0, fe0);
        check_inst(1, a1, b1, max1, mv1, 32'(cg1), 32'(ce1), 32'(cl1), 32'(sc1), ov1, fe1);
        check_inst(2, a2, b2, max2, mv2, 32'(cg2), 32'(ce2), 32'(cl2), 32'(sc2), ov2, fe2);
    endtask

    task automatic sample(input logic [3:0] d);
        step(1'b1, 1'b0, 1'b1, d, 1'b0, 3'b000);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000);
    endtask

    task automatic do_clear();
        step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 3'b000);
    endtask

    initial begin
        // Reset state.
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 3'b000);
        step(1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 3'b000);
        check("rst_max_out", 32'(max0), 0);
        check("rst_out_valid", 32'(ov0), 0);

        // Stream 5, 9, 9, 3, 15 with back-to-back strobes.
        sample(4'd5);  check("t1_ov_1", 32'(ov0), 1);
        sample(4'd9);  check("t1_ov_2", 32'(ov0), 1);
        sample(4'd9);  check("t1_ov_3", 32'(ov0), 1);
        sample(4'd3);  check("t1_ov_4", 32'(ov0), 1);
        sample(4'd15); check("t1_ov_5", 32'(ov0), 1);
        check("t1_max", 32'(max0), 15);
        check("t1_gr", 32'(cg0), 2);
        check("t1_eq", 32'(ce0), 1);
        check("t1_lt", 32'(cl0), 1);
        check("t1_samp", 32'(sc0), 5);
        check("t1_err", 32'(fe0), 0);
        sample(4'd15); check("t1_eq_at_15", 32'(ce0), 2);
        idle();        check("t1_ov_drop", 32'(ov0), 0);

        // First sample 0 after clear, then another 0.
        do_clear();
        sample(4'd0);
        check("t2_valid", 32'(mv0), 1);
        check("t2_max", 32'(max0), 0);
        check("t2_eq0", 32'(ce0), 0);
        sample(4'd0);
        check("t2_eq1", 32'(ce0), 1);

        // Comparator reports eq and gr together on the second sample.
        do_clear();
        sample(4'd4);
        step(1'b1, 1'b0, 1'b1, 4'd7, 1'b1, 3'b110);
        check("t3_err", 32'(fe0), 1);
        check("t3_max", 32'(max0), 4);
        check("t3_gr", 32'(cg0), 0);
        check("t3_samp", 32'(sc0), 2);
        idle();
        sample(4'd8);
        check("t3_err_sticky", 32'(fe0), 1);
        check("t3_max_after", 32'(max0), 8);
        do_clear();
        check("t3_err_cleared", 32'(fe0), 0);

        // Clear together with a sample drops the sample.
        sample(4'd9);
        check("t4_max9", 32'(max0), 9);
        step(1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 3'b000);
        check("t4_valid", 32'(mv0), 0);
        check("t4_samp", 32'(sc0), 0);
        check("t4_ov", 32'(ov0), 0);
        sample(4'd2);
        check("t4_max2", 32'(max0), 2);

        // Five identical samples: four eq events on narrow counters.
        do_clear();
        for (int i = 0; i < 5; i++) sample(4'd6);
        check("t5_eq_w8", 32'(ce0), 4);
        check("t5_eq_sat", 32'(ce1), 3);
        check("t5_eq_wrap", 32'(ce2), 0);
        check("t5_samp_sat", 32'(sc1), 3);
        check("t5_samp_wrap", 32'(sc2), 1);

        // One-cycle reset mid-stream.
        do_clear();
        sample(4'd11);
        sample(4'd4);
        check("t6_max11", 32'(max0), 11);
        step(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 3'b000);
        check("t6_rst_max", 32'(max0), 0);
        check("t6_rst_valid", 32'(mv0), 0);
        sample(4'd1);
        check("t6_max1", 32'(max0), 1);
        check("t6_samp1", 32'(sc0), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 24) == 0),
                 bad_pat[$urandom_range(0, 4)]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/four_bit_max_tracker.md
Name: four_bit_max_tracker

Overview:
- Sequential stage wrapped around the four-bit dataflow magnitude comparator.
- Feeds the comparator: drives operand a with the incoming sample and operand b with the stored running maximum.
- Consumes the comparator's eq/gr/lt outputs to update the running maximum and per-outcome event counters.
- Produces a registered result strobe per accepted sample, plus a sticky error if the comparator flags are ever not one-hot.

Parameters:
CNT_W, 8, width of each event counter and of the sample counter
SAT, 1, 1 = counters saturate at all-ones; 0 = counters wrap to zero

Ports:
clk  input  1  single system clock, rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous clear of all tracking state; same effect as reset
in_valid  input  1  in_data holds a sample this cycle; always accepted, no backpressure
in_data  input  4  unsigned sample
cmp_a  output  4  comparator operand a; combinational copy of in_data
cmp_b  output  4  comparator operand b; copy of max_out register
cmp_eq  input  1  comparator a==b
cmp_gr  input  1  comparator a>b
cmp_lt  input  1  comparator a<b
max_out  output  4  running maximum
max_valid  output  1  max_out holds at least one sample
cnt_gr  output  CNT_W  number of samples that raised the maximum
cnt_eq  output  CNT_W  number of samples equal to the maximum
cnt_lt  output  CNT_W  number of samples below the maximum
sample_cnt  output  CNT_W  total accepted samples
out_valid  output  1  one-cycle pulse, cycle after a sample is accepted
flag_err  output  1  sticky; comparator flags were not one-hot on an accepted sample

Behaviour:
- Reset: all registered outputs are 0 while rst_n=0 at a clk edge.
  - Covers max_out, max_valid, all counters, out_valid and flag_err.
  - State returns to EMPTY.
- The comparator is combinational, so its flags relate to the current in_data and the current max_out within the same cycle.
- State EMPTY (max_valid=0), on in_valid=1:
  - max_out<=in_data, max_valid<=1, sample_cnt<=1, out_valid<=1.
  - cnt_gr, cnt_eq and cnt_lt are unchanged; the comparator flags are ignored.
  - Next state is TRACK.
- State TRACK, on in_valid=1 with exactly one flag set:
  - cmp_gr: max_out<=in_data, cnt_gr+1.
  - cmp_eq: cnt_eq+1, max_out unchanged.
  - cmp_lt: cnt_lt+1, max_out unchanged.
  - sample_cnt+1 and out_valid<=1 in all three cases.
- State TRACK, on in_valid=1 with flags not one-hot (none set, or more than one set):
  - flag_err<=1.
  - max_out and the three event counters are unchanged.
  - sample_cnt+1 and out_valid<=1 still apply.
- in_valid=0: no state change, out_valid<=0.
- Latency: every update is visible on the clk edge that accepts the sample.
  - out_valid is high for exactly the cycle following acceptance.
  - Back-to-back samples give back-to-back out_valid pulses.
- Counter width: when SAT=1, a counter at 2^CNT_W-1 holds its value; when SAT=0, it wraps to 0.
  - Saturation or wrap of one counter never affects the other counters.
- Priority: rst_n=0 over clear=1, and clear=1 over in_valid.
  - A sample presented in the same cycle as a clear is dropped; no out_valid follows it.
- flag_err is cleared only by reset or clear.
- Reset or clear mid-stream discards the stored maximum; the next sample is handled as in EMPTY.
- Boundary: in_data=4'b1111 when max_out=4'b1111 counts as eq; max_out never decreases except through reset or clear.

Test Plan:
1. Reset, then samples 5, 9, 9, 3, 15 on consecutive cycles with the real comparator attached -> final max_out=15, cnt_gr=2, cnt_eq=1, cnt_lt=1, sample_cnt=5, five consecutive out_valid pulses, flag_err=0.
2. First sample 0 after reset -> max_valid=1, max_out=0, all event counters 0; next sample 0 -> cnt_eq=1.
3. Stub comparator driving eq=1 and gr=1 together on the 2nd sample (max=4, in=7) -> flag_err=1, max_out stays 4, cnt_gr=0, sample_cnt=2; flag_err stays 1 until clear.
4. clear and in_valid=1 (in_data=12) asserted together while max_out=9 -> next cycle max_valid=0, all counters 0, out_valid=0; the following sample 2 gives max_out=2.
5. CNT_W=2: SAT=1 with 5 eq samples -> cnt_eq=3; SAT=0 with the same stream -> cnt_eq=0 (wrapped after 4).
6. rst_n=0 for one cycle mid-stream with max_out=11 -> all outputs 0 the next cycle; subsequent sample 1 -> max_out=1, sample_cnt=1.
